layer_out_streamer: RTL and testbench

LAYER_OUT_STREAMER -- requirements
Module: layer_out_streamer

---
 rtl/nn_parameters.sv | 15 +
 rtl/requant_sat.sv | 34 +++
 rtl/layer_out_streamer.sv | 119 +++++++++++
 tb/tb_layer_out_streamer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_parameters.sv
// Shared constants and FSM state type for the dense-layer output path.
package nn_parameters;

    localparam int unsigned OUT_SIZE_2 = 64;
    localparam int unsigned ACC_W      = 24;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned SHIFT      = 8;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StFinish
    } stream_state_e;

endpackage

// File: rtl/requant_sat.sv
// Combinational requantizer: arithmetic right shift, then saturate to a signed OUT_W range.
module requant_sat #(
    parameter int unsigned IN_W  = nn_parameters::ACC_W,
    parameter int unsigned OUT_W = nn_parameters::DATA_W,
    parameter int unsigned SHIFT = nn_parameters::SHIFT
) (
    input  logic [IN_W-1:0]  in_val,
    output logic [OUT_W-1:0] out_val
);

    logic signed [IN_W-1:0] shifted;

    assign shifted = $signed(in_val) >>> SHIFT;

    if (IN_W > OUT_W) begin : g_sat
        // The value fits when every bit from the output sign bit upward agrees.
        logic [IN_W-OUT_W:0] top;

        assign top = shifted[IN_W-1:OUT_W-1];

        always_comb begin
            if ((&top) || !(|top)) begin
                out_val = shifted[OUT_W-1:0];
            end else if (shifted[IN_W-1]) begin
                out_val = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                out_val = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    end else begin : g_ext
        assign out_val = OUT_W'(shifted);
    end

endmodule

// File: rtl/layer_out_streamer.sv
// Captures a dense-layer output vector and streams it element by element with
// requantization, valid/ready handshaking and a running argmax of the raw values.
module layer_out_streamer #(
    parameter int unsigned OUT_SIZE = nn_parameters::OUT_SIZE_2,
    parameter int unsigned ACC_W    = nn_parameters::ACC_W,
    parameter int unsigned DATA_W   = nn_parameters::DATA_W,
    parameter int unsigned SHIFT    = nn_parameters::SHIFT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [OUT_SIZE-1:0][ACC_W-1:0] in_vector,
    output logic                          busy,
    output logic [DATA_W-1:0]             out_data,
    output logic [$clog2(OUT_SIZE)-1:0]   out_index,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic [$clog2(OUT_SIZE)-1:0]   argmax_idx,
    output logic [ACC_W-1:0]              argmax_val,
    output logic                          done
);

    import nn_parameters::*;

    localparam int unsigned   IdxW    = $clog2(OUT_SIZE);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(OUT_SIZE - 1);

    stream_state_e state_q, state_d;

    logic [OUT_SIZE-1:0][ACC_W-1:0] buf_q;
    logic [IdxW-1:0]                cnt_q, cnt_d;
    logic [IdxW-1:0]                amax_idx_q, amax_idx_d;
    logic [ACC_W-1:0]               amax_val_q, amax_val_d;
    logic                           capture;
    logic [ACC_W-1:0]               cur_raw;
    logic [DATA_W-1:0]              cur_req;

    assign cur_raw = buf_q[cnt_q];

    requant_sat #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_W),
        .SHIFT (SHIFT)
    ) u_requant (
        .in_val  (cur_raw),
        .out_val (cur_req)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        amax_idx_d = amax_idx_q;
        amax_val_d = amax_val_q;
        capture    = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = StStream;
                end
            end
            StStream: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    // Element 0 seeds the argmax; strict > keeps the lowest index on ties.
                    if (cnt_q == '0 || $signed(cur_raw) > $signed(amax_val_q)) begin
                        amax_idx_d = cnt_q;
                        amax_val_d = cur_raw;
                    end
                    if (cnt_q == LastIdx) begin
                        state_d = StFinish;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StFinish: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            amax_idx_q <= '0;
            amax_val_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            amax_idx_q <= amax_idx_d;
            amax_val_q <= amax_val_d;
        end
    end

    // Buffer contents are irrelevant outside a stream, so it carries no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_q <= in_vector;
        end
    end

    assign out_data   = out_valid ? cur_req : '0;
    assign out_index  = cnt_q;
    assign out_last   = out_valid && (cnt_q == LastIdx);
    assign argmax_idx = amax_idx_q;
    assign argmax_val = amax_val_q;

endmodule

// File: tb/tb_layer_out_streamer.sv
// Self-checking bench for layer_out_streamer: scoreboarded stream checks, a requantization
// vector table, backpressure, tie-breaking, start-while-busy and mid-stream reset.
module tb_layer_out_streamer;

    localparam int unsigned N  = 64;
    localparam int unsigned AW = 24;
    localparam int unsigned DW = 16;
    localparam int unsigned IW = 6;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  start = 1'b0;
    logic                  out_ready = 1'b0;
    logic [N-1:0][AW-1:0]  in_vector = '0;
    logic                  busy, out_valid, out_last, done;
    logic [DW-1:0]         out_data;
    logic [IW-1:0]         out_index, argmax_idx;
    logic [AW-1:0]         argmax_val;

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
        logic          last;
    } exp_t;

    typedef struct {
        logic [AW-1:0] raw;
        logic [DW-1:0] exp;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   xfers = 0;
    int   cyc = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;
    bit   bp_en = 1'b0;
    int   bp_phase = 0;

    layer_out_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_vector  (in_vector),
        .busy       (busy),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .argmax_idx (argmax_idx),
        .argmax_val (argmax_val),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Floor division by 256, then clamp to the signed 16-bit range.
    function automatic logic [DW-1:0] requant_model(input logic [AW-1:0] r);
        int s;
        s = int'($signed(r));
        if (s < 0) s = -((-s + 255) / 256);
        else       s = s / 256;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return DW'(s);
    endfunction

    function automatic int argmax_model(input logic [N-1:0][AW-1:0] v);
        int best;
        best = 0;
        for (int i = 1; i < N; i++) begin
            if ($signed(v[i]) > $signed(v[best])) best = i;
        end
        return best;
    endfunction

    task automatic push_vector(input logic [N-1:0][AW-1:0] v);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.data = requant_model(v[i]);
            e.idx  = IW'(i);
            e.last = (i == N - 1);
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard monitor plus stall-stability checks, sampled on the falling edge.
    initial begin
        exp_t          e;
        bit            stall;
        logic [DW-1:0] hd;
        logic [IW-1:0] hi;
        logic          hl;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (stall) begin
                    check("stall_valid", {31'b0, out_valid}, 32'd1);
                    if (out_valid) begin
                        check("stall_data", {16'b0, out_data}, {16'b0, hd});
                        check("stall_index", {26'b0, out_index}, {26'b0, hi});
                        check("stall_last", {31'b0, out_last}, {31'b0, hl});
                    end
                end
                if (out_valid && out_ready) begin
                    xfers++;
                    if (xfers == 1) first_cyc = cyc;
                    if (out_last) last_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_xfer: got index %0d want no transfer", out_index);
                    end else begin
                        e = exp_q.pop_front();
                        check("data", {16'b0, out_data}, {16'b0, e.data});
                        check("index", {26'b0, out_index}, {26'b0, e.idx});
                        check("last", {31'b0, out_last}, {31'b0, e.last});
                    end
                end
                stall = out_valid && !out_ready;
                hd = out_data;
                hi = out_index;
                hl = out_last;
            end else begin
                stall = 1'b0;
            end
        end
    end

    // Backpressure pattern 1,0,0,1 repeating.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                out_ready = (bp_phase % 4 == 0) || (bp_phase % 4 == 3);
                bp_phase++;
            end
        end
    end

    task automatic start_stream();
        @(posedge clk);
        #1;
        xfers = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("latency_valid", {31'b0, out_valid}, 32'd1);
        check("latency_busy", {31'b0, busy}, 32'd1);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 400);
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done want done within 400 cycles", name);
        end else begin
            check("done_timing", cyc, last_cyc + 1);
            check("done_busy", {31'b0, busy}, 32'd0);
            check("done_valid", {31'b0, out_valid}, 32'd0);
            check("xfer_count", xfers, N);
            check("queue_empty", exp_q.size(), 0);
            @(negedge clk);
            check("done_pulse", {31'b0, done}, 32'd0);
        end
    endtask

    task automatic check_argmax(input logic [N-1:0][AW-1:0] v);
        int b;
        b = argmax_model(v);
        check("argmax_idx", {26'b0, argmax_idx}, b);
        check("argmax_val", {8'b0, argmax_val}, {8'b0, v[b]});
    endtask

    initial begin
        vec_t                 tbl[11];
        logic [N-1:0][AW-1:0] v, a;
        exp_t                 e;
        int                   n;

        tbl[0]  = '{24'h7FFFFF, 16'h7FFF};
        tbl[1]  = '{24'h800000, 16'h8000};
        tbl[2]  = '{24'hFFFED4, 16'hFFFE};
        tbl[3]  = '{24'h000000, 16'h0000};
        tbl[4]  = '{24'h000100, 16'h0001};
        tbl[5]  = '{24'h0000FF, 16'h0000};
        tbl[6]  = '{24'hFFFFFF, 16'hFFFF};
        tbl[7]  = '{24'hFFFF00, 16'hFFFF};
        tbl[8]  = '{24'h123456, 16'h1234};
        tbl[9]  = '{24'hFFFEFF, 16'hFFFE};
        tbl[10] = '{24'h7FFF80, 16'h7FFF};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_last", {31'b0, out_last}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_data", {16'b0, out_data}, 32'd0);
        check("rst_index", {26'b0, out_index}, 32'd0);
        check("rst_amax_idx", {26'b0, argmax_idx}, 32'd0);
        check("rst_amax_val", {8'b0, argmax_val}, 32'd0);

        // Requantization table; start is raised with reset release for first-edge acceptance.
        v = '0;
        for (int i = 0; i < 11; i++) v[i] = tbl[i].raw;
        for (int i = 0; i < N; i++) begin
            e.data = (i < 11) ? tbl[i].exp : 16'h0000;
            e.idx  = IW'(i);
            e.last = (i == N - 1);
            exp_q.push_back(e);
        end
        in_vector = v;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        xfers = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("first_edge_valid", {31'b0, out_valid}, 32'd1);
        wait_done("table");
        check_argmax(v);

        // Ramp at full throughput.
        for (int i = 0; i < N; i++) v[i] = AW'(i * 256);
        in_vector = v;
        push_vector(v);
        start_stream();
        wait_done("ramp");
        check("ramp_span", last_cyc - first_cyc, N - 1);
        check("ramp_amax_idx", {26'b0, argmax_idx}, 32'd63);
        check("ramp_amax_val", {8'b0, argmax_val}, 32'h3F00);

        // Backpressure with random data.
        for (int i = 0; i < N; i++) v[i] = AW'($urandom);
        in_vector = v;
        push_vector(v);
        bp_phase = 0;
        bp_en = 1'b1;
        start_stream();
        wait_done("backpressure");
        check_argmax(v);
        bp_en = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Ties and negatives.
        for (int i = 0; i < N; i++) v[i] = 24'hFFFFFB;
        v[10] = 24'd100;
        v[20] = 24'd100;
        in_vector = v;
        push_vector(v);
        start_stream();
        wait_done("tie");
        check("tie_amax_idx", {26'b0, argmax_idx}, 32'd10);
        check("tie_amax_val", {8'b0, argmax_val}, 32'd100);

        // Start while busy, with in_vector replaced mid-stream.
        for (int i = 0; i < N; i++) a[i] = AW'($urandom);
        in_vector = a;
        push_vector(a);
        start_stream();
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) v[i] = AW'($urandom);
        v[5] = 24'h7FFFFF;
        in_vector = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("busy_start");
        check_argmax(a);

        // Reset mid-stream at element 30.
        for (int i = 0; i < N; i++) v[i] = AW'(i * 256);
        in_vector = v;
        push_vector(v);
        start_stream();
        n = 0;
        while (out_index != 6'd30 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_index30", {26'b0, out_index}, 32'd30);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_data", {16'b0, out_data}, 32'd0);
        check("midrst_index", {26'b0, out_index}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_amax_idx", {26'b0, argmax_idx}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        for (int i = 0; i < N; i++) v[i] = AW'(N - 1 - i) * 24'd300;
        in_vector = v;
        push_vector(v);
        rst = 1'b1;
        xfers = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("restart_valid", {31'b0, out_valid}, 32'd1);
        check("restart_index", {26'b0, out_index}, 32'd0);
        wait_done("restart");
        check_argmax(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish want finish before 300000");
        $fatal(1);
    end

endmodule
